// File: rtl/snake_pkg.sv
// Shared types, widths and default timing constants for the snake tick scheduler.
// The period helper is shared so the reset value and runtime value cannot drift apart.
package snake_pkg;

    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned TICK_W  = 28;

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd7;

    localparam logic [TICK_W-1:0] DEF_BASE_TICKS = 28'd12_499_999;
    localparam logic [TICK_W-1:0] DEF_STEP_TICKS = 28'd1_250_000;
    localparam logic [TICK_W-1:0] DEF_MIN_TICKS  = 28'd2_499_999;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        MOVE,
        DRAW
    } state_e;

    // Arithmetic is done at 32 bits so an oversized reduction shows up as underflow.
    function automatic logic [TICK_W-1:0] period_for_level(
        input logic [TICK_W-1:0]  base,
        input logic [TICK_W-1:0]  step,
        input logic [TICK_W-1:0]  min_t,
        input logic [LEVEL_W-1:0] lvl
    );
        logic [31:0] reduction;
        logic [31:0] remaining;
        reduction = 32'(lvl) * 32'(step);
        remaining = 32'(base) - reduction;
        if ((reduction > 32'(base)) || (remaining < 32'(min_t))) begin
            return min_t;
        end
        return remaining[TICK_W-1:0];
    endfunction

endpackage

// File: rtl/snake_period_calc.sv
// Combinational mapping from speed level to the clamped divider reload value.
module snake_period_calc
    import snake_pkg::*;
#(
    parameter logic [TICK_W-1:0] BASE_TICKS = DEF_BASE_TICKS,
    parameter logic [TICK_W-1:0] STEP_TICKS = DEF_STEP_TICKS,
    parameter logic [TICK_W-1:0] MIN_TICKS  = DEF_MIN_TICKS
) (
    input  logic [LEVEL_W-1:0] level,
    output logic [TICK_W-1:0]  max_ticks
);

    always_comb begin
        max_ticks = period_for_level(BASE_TICKS, STEP_TICKS, MIN_TICKS, level);
    end

endmodule

// File: rtl/snake_tick_scheduler.sv
// Game-speed scheduler: sequences move/draw handshakes per divider tick and
// drives the external rate divider's reload value and reload strobe.
module snake_tick_scheduler
    import snake_pkg::*;
#(
    parameter logic [TICK_W-1:0] BASE_TICKS = DEF_BASE_TICKS,
    parameter logic [TICK_W-1:0] STEP_TICKS = DEF_STEP_TICKS,
    parameter logic [TICK_W-1:0] MIN_TICKS  = DEF_MIN_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               game_over,
    input  logic               food_eaten,
    input  logic               tick_en,
    input  logic               move_ack,
    input  logic               draw_ack,
    output logic [TICK_W-1:0]  max_ticks,
    output logic               par_load,
    output logic               move_req,
    output logic               draw_req,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               overrun
);

    localparam logic [TICK_W-1:0] RESET_TICKS =
        period_for_level(BASE_TICKS, STEP_TICKS, MIN_TICKS, '0);

    state_e              state_q, state_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [TICK_W-1:0]   max_ticks_q, max_ticks_d;
    logic                par_load_q, par_load_d;
    logic                move_req_q, move_req_d;
    logic                draw_req_q, draw_req_d;
    logic                overrun_q, overrun_d;
    logic                pause_q, pause_d;

    // Period is computed from the next level so max_ticks lands with par_load.
    snake_period_calc #(
        .BASE_TICKS (BASE_TICKS),
        .STEP_TICKS (STEP_TICKS),
        .MIN_TICKS  (MIN_TICKS)
    ) u_period_calc (
        .level     (level_d),
        .max_ticks (max_ticks_d)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        par_load_d = 1'b0;
        pause_d    = pause;

        if (state_q == IDLE) begin
            if (start && !game_over) begin
                state_d    = WAIT_TICK;
                level_d    = '0;
                overrun_d  = 1'b0;
                par_load_d = 1'b1;
            end
        end else if (game_over) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WAIT_TICK: begin
                    // pause_q keeps the reload asserted one cycle past the pause release
                    if (pause || pause_q) begin
                        par_load_d = 1'b1;
                    end
                    if (tick_en && !pause) begin
                        state_d = MOVE;
                    end
                end
                MOVE: begin
                    if (move_ack) begin
                        state_d = DRAW;
                    end
                    if (tick_en) begin
                        overrun_d = 1'b1;
                    end
                end
                DRAW: begin
                    if (draw_ack) begin
                        state_d = WAIT_TICK;
                    end
                    if (tick_en) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (food_eaten && (level_q != MAX_LEVEL)) begin
                level_d    = level_q + 1'b1;
                par_load_d = 1'b1;
            end
        end

        move_req_d = (state_d == MOVE);
        draw_req_d = (state_d == DRAW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            level_q     <= '0;
            max_ticks_q <= RESET_TICKS;
            par_load_q  <= 1'b0;
            move_req_q  <= 1'b0;
            draw_req_q  <= 1'b0;
            overrun_q   <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            max_ticks_q <= max_ticks_d;
            par_load_q  <= par_load_d;
            move_req_q  <= move_req_d;
            draw_req_q  <= draw_req_d;
            overrun_q   <= overrun_d;
            pause_q     <= pause_d;
        end
    end

    assign max_ticks = max_ticks_q;
    assign par_load  = par_load_q;
    assign move_req  = move_req_q;
    assign draw_req  = draw_req_q;
    assign level     = level_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule
